// File: rtl/instr_memory_loader_if.sv
// Program-load and fetch signals between a loader master and instr_memory_loader.
interface instr_memory_loader_if;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic [7:0] pc;
    logic [7:0] instruction;
    logic       cpu_hold;
    logic [8:0] prog_len;
    logic       load_err;

    modport master (
        output load_start, load_valid, load_data, load_last, pc,
        input  load_ready, instruction, cpu_hold, prog_len, load_err
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, pc,
        output load_ready, instruction, cpu_hold, prog_len, load_err
    );
endinterface

// File: rtl/instr_memory_loader.sv
// 256x8 instruction store: streams a program in, then serves zero-latency fetches.
// Optional macro CHECKSUM_EN: final beat is a checksum byte, mismatch lands in an error state.
module instr_memory_loader (
    input logic                   clk,
    input logic                   reset,
    instr_memory_loader_if.slave  bus
);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StLoad, StRun, StError} state_t;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_t;
`endif

    state_t     state_q;
    logic [7:0] addr_q;
    logic [8:0] prog_len_q;
    logic [7:0] mem [256];
    logic       accept;
    logic       store;

`ifdef CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] check_total;
    logic       load_err_q;
`endif

    // load_start pre-empts any beat offered in the same cycle
    always_comb begin
        accept = bus.load_valid && (state_q == StLoad) && !bus.load_start;
`ifdef CHECKSUM_EN
        store       = accept && !bus.load_last;
        check_total = sum_q + bus.load_data;
`else
        store       = accept;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= 8'h00;
            prog_len_q <= 9'd0;
`ifdef CHECKSUM_EN
            sum_q      <= 8'h00;
            load_err_q <= 1'b0;
`endif
        end else if (bus.load_start) begin
            state_q    <= StLoad;
            addr_q     <= 8'h00;
            prog_len_q <= 9'd0;
`ifdef CHECKSUM_EN
            sum_q      <= 8'h00;
            load_err_q <= 1'b0;
`endif
        end else if (accept) begin
`ifdef CHECKSUM_EN
            if (bus.load_last) begin
                if (check_total == 8'h00) begin
                    state_q <= StRun;
                end else begin
                    state_q    <= StError;
                    load_err_q <= 1'b1;
                end
            end else begin
                addr_q     <= addr_q + 8'd1;
                prog_len_q <= prog_len_q + 9'd1;
                sum_q      <= check_total;
                // a full memory ends the load without a checksum
                if (prog_len_q == 9'd255) begin
                    state_q <= StRun;
                end
            end
`else
            addr_q     <= addr_q + 8'd1;
            prog_len_q <= prog_len_q + 9'd1;
            // a full memory ends the load, so the wrapped addr is never written
            if (bus.load_last || (prog_len_q == 9'd255)) begin
                state_q <= StRun;
            end
`endif
        end
    end

    // Contents survive reset; prog_len alone decides what is readable
    always_ff @(posedge clk) begin
        if (store) begin
            mem[addr_q] <= bus.load_data;
        end
    end

    always_comb begin
        bus.instruction = 8'h00;
        if ((state_q == StRun) && ({1'b0, bus.pc} < prog_len_q)) begin
            bus.instruction = mem[bus.pc];
        end
    end

    assign bus.load_ready = (state_q == StLoad);
    assign bus.cpu_hold   = (state_q != StRun);
    assign bus.prog_len   = prog_len_q;
`ifdef CHECKSUM_EN
    assign bus.load_err   = load_err_q;
`else
    assign bus.load_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_memory_loader.sv
// Directed bench for instr_memory_loader; checksum vectors apply when CHECKSUM_EN is defined.
module tb_instr_memory_loader;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] prog [$];

    instr_memory_loader_if bus ();

    instr_memory_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        @(posedge clk);
        #1;
        bus.load_start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    // Sends prog[]; last flag on final byte, or an appended checksum byte with CHECKSUM_EN
    task automatic send_prog();
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < prog.size(); i++) begin
            s = s + prog[i];
`ifdef CHECKSUM_EN
            beat(prog[i], 1'b0);
`else
            beat(prog[i], i == prog.size() - 1);
`endif
        end
`ifdef CHECKSUM_EN
        beat(8'h00 - s, 1'b1);
`endif
    endtask

    task automatic fetch(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        bus.pc = addr;
        #1;
        check(tag, bus.instruction, exp);
    endtask

    initial begin
        reset          = 1'b1;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.load_last  = 1'b0;
        bus.pc         = 8'h00;
        #12;
        check("rst_hold", bus.cpu_hold, 1);
        check("rst_ready", bus.load_ready, 0);
        check("rst_len", bus.prog_len, 0);
        check("rst_instr", bus.instruction, 8'h00);
        check("rst_err", bus.load_err, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic three-byte program
        start_load();
        check("load_ready", bus.load_ready, 1);
        check("load_hold", bus.cpu_hold, 1);
`ifdef CHECKSUM_EN
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'hFD, 1'b1);
        check("cs_ok_hold", bus.cpu_hold, 0);
        check("cs_ok_len", bus.prog_len, 2);
        check("cs_ok_err", bus.load_err, 0);
        fetch("cs_ok_pc1", 8'd1, 8'h02);
        fetch("cs_ok_pc2", 8'd2, 8'h00);
        start_load();
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'hFE, 1'b1);
        check("cs_bad_err", bus.load_err, 1);
        check("cs_bad_hold", bus.cpu_hold, 1);
        check("cs_bad_ready", bus.load_ready, 0);
        fetch("cs_bad_instr", 8'd0, 8'h00);
`else
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b1);
        check("run_hold", bus.cpu_hold, 0);
        check("run_ready", bus.load_ready, 0);
        check("run_len", bus.prog_len, 3);
        check("run_err", bus.load_err, 0);
        fetch("run_pc0", 8'd0, 8'h11);
        fetch("run_pc1", 8'd1, 8'h22);
        fetch("run_pc2", 8'd2, 8'h33);
        fetch("run_pc3", 8'd3, 8'h00);
`endif

        // Reset in the middle of a load
        start_load();
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        bus.pc = 8'd0;
        #2;
        reset = 1'b1;
        #1;
        check("abort_hold", bus.cpu_hold, 1);
        check("abort_ready", bus.load_ready, 0);
        check("abort_len", bus.prog_len, 0);
        check("abort_instr", bus.instruction, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        start_load();
        prog = '{8'hAA, 8'hBB};
        send_prog();
        check("reload_hold", bus.cpu_hold, 0);
        check("reload_len", bus.prog_len, 2);
        fetch("reload_pc0", 8'd0, 8'hAA);
        fetch("reload_pc1", 8'd1, 8'hBB);

        // Full 256-byte image without load_last
        start_load();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                check("full_pre_hold", bus.cpu_hold, 1);
            end
            beat(8'(i) ^ 8'hA5, 1'b0);
        end
        check("full_hold", bus.cpu_hold, 0);
        check("full_len", bus.prog_len, 256);
        fetch("full_pc0", 8'd0, 8'hA5);
        fetch("full_pc128", 8'd128, 8'h25);
        fetch("full_pc255", 8'd255, 8'h5A);
        beat(8'hEE, 1'b0);
        check("extra_len", bus.prog_len, 256);
        fetch("extra_pc0", 8'd0, 8'hA5);

        // load_start beats a same-cycle beat in RUN
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h77;
        #1;
        check("preempt_pre_hold", bus.cpu_hold, 0);
        @(posedge clk);
        #1;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        check("preempt_hold", bus.cpu_hold, 1);
        check("preempt_ready", bus.load_ready, 1);
        check("preempt_len", bus.prog_len, 0);
        prog = '{8'h12};
        send_prog();
        check("preempt_run_len", bus.prog_len, 1);
        fetch("preempt_pc0", 8'd0, 8'h12);
        fetch("preempt_pc1", 8'd1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
